// File: rtl/fetch_line_buffer_if.sv
// fetch_line_buffer_if: fetch-stage lookup, flush, line-fetcher and statistics signals of fetch_line_buffer.
interface fetch_line_buffer_if #(
    parameter int BUS_DATA_WIDTH    = 64,
    parameter int LINE_WIDTH        = 512,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int STAT_WIDTH        = 32
);
    logic                         req_valid;
    logic [BUS_DATA_WIDTH-1:0]    req_pc;
    logic                         req_ready;
    logic                         flush;
    logic                         resp_valid;
    logic [INSTRUCTION_WIDTH-1:0] resp_inst;
    logic                         resp_misaligned;
    logic                         fetch_enable;
    logic [BUS_DATA_WIDTH-1:0]    fetch_addr;
    logic                         fetch_ready;
    logic [LINE_WIDTH-1:0]        fetch_data;
    logic [STAT_WIDTH-1:0]        hit_count;
    logic [STAT_WIDTH-1:0]        miss_count;

    modport slave (
        input  req_valid, req_pc, flush, fetch_ready, fetch_data,
        output req_ready, resp_valid, resp_inst, resp_misaligned,
               fetch_enable, fetch_addr, hit_count, miss_count
    );

    modport master (
        output req_valid, req_pc, flush, fetch_ready, fetch_data,
        input  req_ready, resp_valid, resp_inst, resp_misaligned,
               fetch_enable, fetch_addr, hit_count, miss_count
    );
endinterface

// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer: single 64-byte line buffer answering fetch-stage PC lookups, refilling from the line fetcher on a miss.
// Hit/miss counters are built only when FETCH_LINE_STATS_EN is defined; otherwise both read as zero.
module fetch_line_buffer #(
    parameter int BUS_DATA_WIDTH    = 64,
    parameter int LINE_WIDTH        = 512,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int STAT_WIDTH        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_line_buffer_if.slave   bus
);
    localparam int TAG_W = BUS_DATA_WIDTH - 6;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, WAIT_DROP, WAIT_READY, FILL} state_e;

    state_e                       state_q, state_d;
    logic [LINE_WIDTH-1:0]        line_q, line_d;
    logic [TAG_W-1:0]             tag_q, tag_d;
    logic                         valid_q, valid_d;
    logic                         flushed_q, flushed_d;
    logic [BUS_DATA_WIDTH-1:0]    pc_q, pc_d;
    logic [BUS_DATA_WIDTH-1:0]    addr_q, addr_d;
    logic [INSTRUCTION_WIDTH-1:0] inst_q;
    logic [INSTRUCTION_WIDTH-1:0] sel;
    logic                         hit;

    assign hit = valid_q && (tag_q == pc_q[BUS_DATA_WIDTH-1:6]);
    assign sel = line_q[{pc_q[5:2], 5'd0} +: INSTRUCTION_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            line_q    <= '0;
            tag_q     <= '0;
            valid_q   <= 1'b0;
            flushed_q <= 1'b0;
            pc_q      <= '0;
            addr_q    <= '0;
            inst_q    <= '0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
            flushed_q <= flushed_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            inst_q    <= bus.resp_inst;
        end
    end

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        flushed_d = flushed_q | bus.flush;
        pc_d      = pc_q;
        addr_d    = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    pc_d    = bus.req_pc;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                state_d = hit ? IDLE : MISS_REQ;
                if (!hit) begin
                    addr_d    = {pc_q[BUS_DATA_WIDTH-1:6], 6'b0};
                    flushed_d = bus.flush;
                end
            end
            MISS_REQ:   state_d = WAIT_DROP;
            // a READY level left over from the previous fetch must fall before a line is trusted
            WAIT_DROP:  state_d = bus.fetch_ready ? WAIT_DROP : WAIT_READY;
            WAIT_READY: begin
                if (bus.fetch_ready) begin
                    line_d  = bus.fetch_data;
                    tag_d   = pc_q[BUS_DATA_WIDTH-1:6];
                    valid_d = !flushed_d;
                    state_d = FILL;
                end
            end
            FILL:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        if (bus.flush) valid_d = 1'b0;
    end

    assign bus.req_ready       = (state_q == IDLE);
    assign bus.resp_valid      = (state_q == LOOKUP && hit) || (state_q == FILL);
    assign bus.resp_inst       = bus.resp_valid ? sel : inst_q;
    assign bus.resp_misaligned = bus.resp_valid && (pc_q[1:0] != 2'b00);
    assign bus.fetch_enable    = (state_q == MISS_REQ);
    assign bus.fetch_addr      = addr_q;

`ifdef FETCH_LINE_STATS_EN
    logic [STAT_WIDTH-1:0] hits_q, misses_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit && !(&hits_q)) hits_q <= hits_q + STAT_WIDTH'(1);
            if (!hit && !(&misses_q)) misses_q <= misses_q + STAT_WIDTH'(1);
        end
    end

    assign bus.hit_count  = hits_q;
    assign bus.miss_count = misses_q;
`else
    assign bus.hit_count  = '0;
    assign bus.miss_count = '0;
`endif
endmodule

// File: tb/tb_fetch_line_buffer.sv
// tb_fetch_line_buffer: scoreboard bench for fetch_line_buffer with a behavioural line-fetcher model.
module tb_fetch_line_buffer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_line_buffer_if bus ();
    fetch_line_buffer dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef FETCH_LINE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic        mis;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          resp_cyc = -1;
    int          enables = 0;
    int          exp_h = 0;
    int          exp_m = 0;
    logic [63:0] last_en_addr = '0;

    // every word of a line encodes its line address and index; line 0x1000 holds word i = i
    function automatic logic [511:0] line_of(input logic [63:0] a);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = (a[31:0] - 32'h1000) | 32'(i);
        return l;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.fetch_enable) begin
            enables++;
            last_en_addr = bus.fetch_addr;
        end
        if (bus.resp_valid) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_resp inst=%h", bus.resp_inst);
            end else begin
                e = q.pop_front();
                resp_cyc = cyc;
                if (bus.resp_inst !== e.inst || bus.resp_misaligned !== e.mis) begin
                    mismatched++;
                    $display("FAIL resp got inst=%h mis=%b want inst=%h mis=%b",
                             bus.resp_inst, bus.resp_misaligned, e.inst, e.mis);
                end
            end
        end
    end

    // line fetcher: READY stays high after a line until the next start pulse has been seen for a while
    initial begin : fetcher
        logic [63:0] a;
        bus.fetch_ready = 1'b0;
        bus.fetch_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.fetch_enable) begin
                a = bus.fetch_addr;
                repeat (2) @(negedge clk);
                bus.fetch_ready = 1'b0;
                repeat (2) @(negedge clk);
                bus.fetch_data  = line_of(a);
                bus.fetch_ready = 1'b1;
            end
        end
    end

    task automatic run_req(input logic [63:0] pc, input bit fl, input bit fl_mid, input bit miss,
                           output int n_en, output int lat, output bit done);
        logic [511:0] l;
        exp_t         x;
        int           e0, c0;
        @(negedge clk);
        l = line_of({pc[63:6], 6'b0});
        x.inst = l[{pc[5:2], 5'd0} +: 32];
        x.mis  = |pc[1:0];
        q.push_back(x);
        if (miss) exp_m++; else exp_h++;
        e0 = enables;
        c0 = cyc;
        resp_cyc = -1;
        bus.req_valid = 1'b1;
        bus.req_pc    = pc;
        bus.flush     = fl;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        if (fl_mid) begin
            for (int i = 0; i < 20 && bus.fetch_ready !== 1'b0; i++) @(negedge clk);
            @(negedge clk);
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
        end
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        done = (q.size() == 0);
        if (!done) q.delete();
        @(negedge clk);
        n_en = enables - e0;
        lat  = resp_cyc - c0;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_pc    = '0;
        bus.flush     = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_inst !== 32'h0 ||
            bus.resp_misaligned !== 1'b0 || bus.fetch_enable !== 1'b0 || bus.fetch_addr !== 64'h0) begin
            mismatched++;
            $display("FAIL reset_outputs rdy=%b rv=%b inst=%h mis=%b en=%b addr=%h want 1 0 0 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_inst, bus.resp_misaligned,
                     bus.fetch_enable, bus.fetch_addr);
        end
        compared++;
        if (bus.hit_count !== 32'h0 || bus.miss_count !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_counts hit=%0d miss=%0d want 0 0", bus.hit_count, bus.miss_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_cold_miss();
        int n_en, lat;
        bit done;
        run_req(64'h1008, 1'b0, 1'b0, 1'b1, n_en, lat, done);
        compared++;
        if (!done || n_en !== 1) begin
            mismatched++;
            $display("FAIL cold_miss done=%b enables=%0d want done=1 enables=1", done, n_en);
        end
        compared++;
        if (last_en_addr !== 64'h1000 || bus.fetch_addr !== 64'h1000) begin
            mismatched++;
            $display("FAIL cold_miss_addr pulse=%h held=%h want 1000", last_en_addr, bus.fetch_addr);
        end
        compared++;
        if (bus.miss_count !== 32'(STATS ? exp_m : 0) || bus.hit_count !== 32'(STATS ? exp_h : 0)) begin
            mismatched++;
            $display("FAIL cold_miss_counts hit=%0d miss=%0d want %0d %0d", bus.hit_count, bus.miss_count,
                     STATS ? exp_h : 0, STATS ? exp_m : 0);
        end
    endtask

    task automatic test_hit();
        int n_en, lat;
        bit done;
        run_req(64'h103C, 1'b0, 1'b0, 1'b0, n_en, lat, done);
        compared++;
        if (!done || n_en !== 0 || lat !== 1) begin
            mismatched++;
            $display("FAIL hit done=%b enables=%0d latency=%0d want 1 0 1", done, n_en, lat);
        end
        compared++;
        if (bus.hit_count !== 32'(STATS ? exp_h : 0)) begin
            mismatched++;
            $display("FAIL hit_count got %0d want %0d", bus.hit_count, STATS ? exp_h : 0);
        end
    endtask

    task automatic test_misaligned();
        int n_en, lat;
        bit done;
        run_req(64'h1002, 1'b0, 1'b0, 1'b0, n_en, lat, done);
        compared++;
        if (!done || n_en !== 0 || lat !== 1) begin
            mismatched++;
            $display("FAIL misaligned done=%b enables=%0d latency=%0d want 1 0 1", done, n_en, lat);
        end
    endtask

    task automatic test_stale_ready();
        int n_en, lat;
        bit done;
        run_req(64'h2000, 1'b0, 1'b0, 1'b1, n_en, lat, done);
        compared++;
        if (!done || n_en !== 1 || last_en_addr !== 64'h2000) begin
            mismatched++;
            $display("FAIL stale_ready done=%b enables=%0d addr=%h want 1 1 2000", done, n_en, last_en_addr);
        end
    endtask

    task automatic test_flush_mid_miss();
        int n_en, lat;
        bit done;
        run_req(64'h3000, 1'b0, 1'b1, 1'b1, n_en, lat, done);
        compared++;
        if (!done || n_en !== 1) begin
            mismatched++;
            $display("FAIL flush_mid_resp done=%b enables=%0d want 1 1", done, n_en);
        end
        run_req(64'h3004, 1'b0, 1'b0, 1'b1, n_en, lat, done);
        compared++;
        if (!done || n_en !== 1 || last_en_addr !== 64'h3000) begin
            mismatched++;
            $display("FAIL flush_mid_refetch done=%b enables=%0d addr=%h want 1 1 3000", done, n_en, last_en_addr);
        end
    endtask

    task automatic test_flush_with_req();
        int n_en, lat;
        bit done;
        run_req(64'h3008, 1'b1, 1'b0, 1'b1, n_en, lat, done);
        compared++;
        if (!done || n_en !== 1) begin
            mismatched++;
            $display("FAIL flush_with_req done=%b enables=%0d want 1 1", done, n_en);
        end
        compared++;
        if (bus.miss_count !== 32'(STATS ? exp_m : 0)) begin
            mismatched++;
            $display("FAIL miss_count got %0d want %0d", bus.miss_count, STATS ? exp_m : 0);
        end
    endtask

    task automatic test_back_to_back();
        int n_en, lat;
        bit done;
        for (int k = 0; k < 4; k++) begin
            run_req(64'h3010 + 64'(k * 4), 1'b0, 1'b0, 1'b0, n_en, lat, done);
            compared++;
            if (!done || n_en !== 0 || lat !== 1) begin
                mismatched++;
                $display("FAIL back_to_back[%0d] done=%b enables=%0d latency=%0d want 1 0 1", k, done, n_en, lat);
            end
        end
    endtask

    task automatic test_async_reset();
        int n_en, lat;
        bit done;
        logic [511:0] l;
        exp_t x;
        @(negedge clk);
        l = line_of(64'h4000);
        x.inst = l[31:0];
        x.mis  = 1'b0;
        q.push_back(x);
        bus.req_valid = 1'b1;
        bus.req_pc    = 64'h4000;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20 && bus.fetch_enable !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        compared++;
        if (bus.resp_valid !== 1'b0 || bus.resp_inst !== 32'h0 || bus.resp_misaligned !== 1'b0 ||
            bus.fetch_enable !== 1'b0 || bus.fetch_addr !== 64'h0 || bus.req_ready !== 1'b1 ||
            bus.hit_count !== 32'h0 || bus.miss_count !== 32'h0) begin
            mismatched++;
            $display("FAIL async_reset rv=%b inst=%h mis=%b en=%b addr=%h rdy=%b hit=%0d miss=%0d want all 0, rdy=1",
                     bus.resp_valid, bus.resp_inst, bus.resp_misaligned, bus.fetch_enable,
                     bus.fetch_addr, bus.req_ready, bus.hit_count, bus.miss_count);
        end
        q.delete();
        exp_h = 0;
        exp_m = 0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL async_reset_ready got %b want 1", bus.req_ready);
        end
        run_req(64'h1000, 1'b0, 1'b0, 1'b1, n_en, lat, done);
        compared++;
        if (!done || n_en !== 1) begin
            mismatched++;
            $display("FAIL async_reset_invalid done=%b enables=%0d want 1 1", done, n_en);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_misaligned();
        test_stale_ready();
        test_flush_mid_miss();
        test_flush_with_req();
        test_back_to_back();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fetch_line_buffer.md
Name: fetch_line_buffer

Overview:
- Single-line instruction buffer sitting directly downstream of the 512-bit line fetcher (addr_to_data) in the fetch path.
- Accepts PC lookups from the fetch stage and returns one 32-bit instruction per lookup.
- On a hit it answers from the buffered 64-byte line; on a miss it triggers the line fetcher, captures its 512-bit line, then answers.
- Provides the fetcher's enable/addr and consumes its ready/data.

Parameters:
- BUS_DATA_WIDTH, 64, address/PC width
- LINE_WIDTH, 512, cache line width in bits (BUS_DATA_WIDTH*8)
- INSTRUCTION_WIDTH, 32, instruction width returned to fetch stage
- STAT_WIDTH, 32, width of hit/miss statistic counters

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  lookup request from fetch stage
- req_pc  in  BUS_DATA_WIDTH  PC to look up
- req_ready  out  1  block can accept a lookup this cycle
- flush  in  1  invalidate buffered line
- resp_valid  out  1  one-cycle pulse, resp_inst valid
- resp_inst  out  INSTRUCTION_WIDTH  instruction at req_pc
- resp_misaligned  out  1  accompanies resp_valid; req_pc[1:0]!=0
- fetch_enable  out  1  start pulse to line fetcher
- fetch_addr  out  BUS_DATA_WIDTH  line-aligned address to fetcher
- fetch_ready  in  1  fetcher line-ready level
- fetch_data  in  LINE_WIDTH  fetched line; bits [63:0] = bytes 0..7, little-endian
- hit_count  out  STAT_WIDTH  hit counter (see Optional Feature)
- miss_count  out  STAT_WIDTH  miss counter (see Optional Feature)

Behaviour:
- Storage: line_data[511:0], line_tag = pc[63:6], line_valid.
- Reset (async, active-high): state IDLE, line_valid=0, line_tag=0, line_data=0, latched PC=0, req_ready=1, resp_valid=0, resp_inst=0, resp_misaligned=0, fetch_enable=0, fetch_addr=0, counters=0.
- States: IDLE, LOOKUP, MISS_REQ, WAIT_DROP, WAIT_READY, FILL.
- IDLE: req_ready=1. A request is accepted when req_valid=1. On accept, latch req_pc and go to LOOKUP.
- LOOKUP: req_ready=0. Hit is line_valid && line_tag==pc[63:6].
  - Hit: resp_valid=1 this cycle, then IDLE. Hit latency is 1 cycle after accept.
  - Miss: go to MISS_REQ.
- MISS_REQ: fetch_enable=1 for exactly one cycle; fetch_addr = {pc[63:6],6'b0}. Next state WAIT_DROP.
- fetch_addr is held stable from MISS_REQ until FILL exits.
- WAIT_DROP: wait for fetch_ready=0. The fetcher's previous READY level may still be high, so this state prevents capturing a stale line. Next state WAIT_READY.
- WAIT_READY: wait for fetch_ready=1. Then capture line_data <= fetch_data and line_tag <= pc[63:6]; line_valid <= 1 unless a flush occurred during the miss. Next state FILL.
- FILL: resp_valid=1 with the instruction selected from the new line, then IDLE.
- Instruction select: byte offset o = pc[5:2]*4; resp_inst = line[o*8 +: 32]. Offsets 0..60 only, so there is no wrap across lines.
- resp_misaligned = (pc[1:0]!=0). The instruction is still taken from word pc[5:2].
- resp_inst holds its last value when resp_valid=0.
- flush:
  - Clears line_valid in any state.
  - flush together with req_valid in IDLE: request accepted, lookup misses.
  - flush during MISS_REQ, WAIT_DROP or WAIT_READY: fetch completes and the response is still delivered, but line_valid stays 0.
- A request while req_ready=0 is ignored; the fetch stage must hold it.
- No timeout; a hung fetcher holds the block in WAIT_READY until reset.

Optional Feature:
- Macro FETCH_LINE_STATS_EN.
- Defined: hit_count increments on each LOOKUP hit; miss_count increments on each LOOKUP miss. Both saturate at all-ones and reset to 0.
- Undefined: both outputs tied to 0 and no counter flops are synthesised.

Test Plan:
- Cold miss: reset, req_pc=0x1008.
  - fetch_enable pulses once with fetch_addr=0x1000.
  - Model drops fetch_ready, then raises it with line word i=i.
  - Expect resp_valid once, resp_inst=0x00000002, miss_count=1.
- Hit after fill: req_pc=0x103C. Expect resp_valid on the cycle after accept, resp_inst=word 15, no fetch_enable, hit_count=1.
- Stale-ready guard: fetch_ready held high before the miss at 0x2000. Expect no capture until fetch_ready goes 0 then 1, and data from the new line.
- Flush mid-miss: assert flush in WAIT_READY for 0x3000.
  - Response is delivered.
  - A following req 0x3004 misses again, with fetch_addr=0x3000.
- Misaligned: req_pc=0x1002 on a valid line. Expect resp_misaligned=1 and resp_inst=word 0.
- Async reset mid-miss: assert reset in WAIT_DROP. Expect all outputs zero immediately; req_ready=1 after release; line_valid=0.
